// File: rtl/blram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
// Holds the read-during-write encodings, the clear/run FSM states and the byte-merge helper.
package blram_pkg;

    localparam int RD_FIRST    = 0;
    localparam int WR_FIRST    = 1;
    localparam int MERGE_MAX_W = 512;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    // Callers zero-extend into MERGE_MAX_W and cast the result back to their own width.
    function automatic logic [MERGE_MAX_W-1:0] bytes_merge(
        input logic [MERGE_MAX_W-1:0]   old_w,
        input logic [MERGE_MAX_W-1:0]   new_w,
        input logic [MERGE_MAX_W/8-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MERGE_MAX_W/8; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/blram_out_pipe.sv
// Per-port read result pipeline: zero stages (pass-through) or one register stage.
// Latency 0 or 1 extra cycle; no backpressure, data holds when no read completes.
module blram_out_pipe #(
    parameter int DATA_W  = 16,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    output logic              o_err,
    output logic [DATA_W-1:0] o_dat
);

    generate
        if (OUT_REG != 0) begin : g_reg
            logic              r_vld;
            logic              r_err;
            logic [DATA_W-1:0] r_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_err <= 1'b0;
                    r_dat <= '0;
                end else begin
                    r_vld <= i_vld;
                    r_err <= i_err;
                    if (i_vld) r_dat <= i_dat;
                end
            end

            assign o_vld = r_vld;
            assign o_err = r_err;
            assign o_dat = r_dat;
        end else begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_vld    = i_vld;
            assign o_err    = i_err;
            assign o_dat    = i_dat;
        end
    endgenerate

endmodule

// File: rtl/blram_dp.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only, post-reset clear walk.
// Latency 1+OUT_REG cycles, one request per port per cycle; requests are dropped while o_busy is high.
module blram_dp
    import blram_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 13,
    parameter int                DEPTH        = 8192,
    parameter int                WRITE_MODE   = 0,
    parameter int                OUT_REG      = 0,
    parameter int                CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    parameter string             INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_a_en,
    input  logic                i_a_we,
    input  logic [DATA_W/8-1:0] i_a_be,
    input  logic [ADDR_W-1:0]   i_a_addr,
    input  logic [DATA_W-1:0]   i_a_wdata,
    output logic [DATA_W-1:0]   o_a_rdata,
    output logic                o_a_rvalid,
    output logic                o_a_err,
    input  logic                i_b_en,
    input  logic [ADDR_W-1:0]   i_b_addr,
    output logic [DATA_W-1:0]   o_b_rdata,
    output logic                o_b_rvalid,
    output logic                o_b_err,
    output logic                o_busy
);

    localparam int              NB      = DATA_W / 8;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic              r_busy;
    logic              r_a_vld, r_a_err, r_b_vld, r_b_err;
    logic [DATA_W-1:0] r_a_dat, r_b_dat;

    logic              w_run, w_a_req, w_b_req, w_a_ok, w_b_ok, w_a_wr, w_clr_wr, w_coll;
    logic [IDX_W-1:0]  w_a_idx, w_b_idx;
    logic [DATA_W-1:0] w_a_old, w_b_old, w_a_merged, w_a_rd_dat, w_b_rd_dat;

    assign w_run    = (r_state == S_RUN) && !rst;
    assign w_a_req  = w_run && i_a_en;
    assign w_b_req  = w_run && i_b_en;
    assign w_a_ok   = {1'b0, i_a_addr} < DEPTH_L;
    assign w_b_ok   = {1'b0, i_b_addr} < DEPTH_L;
    assign w_a_idx  = i_a_addr[IDX_W-1:0];
    assign w_b_idx  = i_b_addr[IDX_W-1:0];
    assign w_a_wr   = w_a_req && i_a_we && w_a_ok;
    assign w_clr_wr = (r_state == S_CLEAR) && !rst;
    assign w_coll   = w_a_wr && (i_a_addr == i_b_addr);

    assign w_a_old    = r_mem[w_a_idx];
    assign w_b_old    = r_mem[w_b_idx];
    assign w_a_merged = DATA_W'(bytes_merge(MERGE_MAX_W'(w_a_old), MERGE_MAX_W'(i_a_wdata),
                                            (MERGE_MAX_W/8)'(i_a_be)));

    // Out-of-range reads return zero; write-first returns the merged word on A and forwards it to B.
    assign w_a_rd_dat = !w_a_ok ? '0 :
                        (WRITE_MODE == WR_FIRST && i_a_we) ? w_a_merged : w_a_old;
    assign w_b_rd_dat = !w_b_ok ? '0 :
                        (WRITE_MODE == WR_FIRST && w_coll) ? w_a_merged : w_b_old;

    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_cnt] <= CLEAR_VALUE;
        end else if (w_a_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (i_a_be[k]) r_mem[w_a_idx][8*k +: 8] <= i_a_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
            r_busy    <= (CLEAR_ON_RST != 0);
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + IDX_W'(1);
            if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_vld <= 1'b0;
            r_a_err <= 1'b0;
            r_a_dat <= '0;
            r_b_vld <= 1'b0;
            r_b_err <= 1'b0;
            r_b_dat <= '0;
        end else begin
            r_a_vld <= w_a_req;
            r_a_err <= w_a_req && !w_a_ok;
            r_b_vld <= w_b_req;
            r_b_err <= w_b_req && !w_b_ok;
            if (w_a_req) r_a_dat <= w_a_rd_dat;
            if (w_b_req) r_b_dat <= w_b_rd_dat;
        end
    end

    blram_out_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
        .clk   (clk),
        .rst   (rst),
        .i_vld (r_a_vld),
        .i_err (r_a_err),
        .i_dat (r_a_dat),
        .o_vld (o_a_rvalid),
        .o_err (o_a_err),
        .o_dat (o_a_rdata)
    );

    blram_out_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
        .clk   (clk),
        .rst   (rst),
        .i_vld (r_b_vld),
        .i_err (r_b_err),
        .i_dat (r_b_dat),
        .o_vld (o_b_rvalid),
        .o_err (o_b_err),
        .o_dat (o_b_rdata)
    );

    assign o_busy = r_busy;

endmodule
